// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state type and default sizes for the fetch sequencer
package Definitions;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int PC_W_DEF      = 10;
    localparam int LUT_DEPTH_DEF = 16;

endpackage

// File: rtl/fetch_sequencer_branch_lut.sv
// rtl/fetch_sequencer_branch_lut.sv - branch target table, split hi/lo byte write, combinational read
module branch_lut
    import Definitions::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_DEPTH = LUT_DEPTH_DEF,
    parameter int IDX_W     = $clog2(LUT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PC_W-1:0]  rd_data,
    input  logic             wr_en,
    input  logic             wr_hi,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data
);

    logic [PC_W-1:0] entries [LUT_DEPTH];

    // Read sees the pre-edge contents, so a same-cycle write/branch uses the old target.
    assign rd_data = entries[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_hi) begin
                entries[wr_idx][PC_W-1:8] <= wr_data[PC_W-9:0];
            end else begin
                entries[wr_idx][7:0] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC / branch sequencer with Start/Ack handshake and HLT stop
// Optional executed-instruction counter: define FETCH_CYCLE_COUNT_EN.
module fetch_sequencer
    import Definitions::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [8:0]      Instruction,
    input  logic [7:0]      Acc_Data,
    input  logic            Halt_Req,
    input  logic            PC_Jmp_Flag,
    input  logic            PC_Beq_Flag,
    input  logic            LUT_Write_En,
    input  logic            LUT_Load_Hi,
    output logic [PC_W-1:0] PC,
    output logic            Instr_Valid,
    output logic            Ack,
    output logic            Overrun,
    output logic [15:0]     Cycle_Count
);

    localparam int IDX_W = $clog2(LUT_DEPTH);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            overrun_q, overrun_d;
    logic            ack_q;
    logic            start_accept;
    logic            lut_wr;
    logic [PC_W-1:0] lut_target;
    logic [IDX_W-1:0] lut_idx;
    logic            unused_bits;

    assign lut_idx     = Instruction[IDX_W-1:0];
    assign unused_bits = ^Instruction[8:IDX_W];
    assign lut_wr      = (state_q == RUN) && LUT_Write_En;

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_lut (
        .clk     (Clk),
        .rst     (Reset),
        .rd_idx  (lut_idx),
        .rd_data (lut_target),
        .wr_en   (lut_wr),
        .wr_hi   (LUT_Load_Hi),
        .wr_idx  (lut_idx),
        .wr_data (Acc_Data)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        overrun_d    = overrun_q;
        start_accept = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (Start) begin
                    start_accept = 1'b1;
                    state_d      = RUN;
                    pc_d         = '0;
                    overrun_d    = 1'b0;
                end
            end
            RUN: begin
                if (Halt_Req) begin
                    state_d = HALT;
                end else if (PC_Jmp_Flag || PC_Beq_Flag) begin
                    pc_d = lut_target;
                end else if (pc_q == {PC_W{1'b1}}) begin
                    // No wrap: falling off the end of memory stops the program.
                    state_d   = HALT;
                    overrun_d = 1'b1;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            overrun_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            overrun_q <= overrun_d;
            ack_q     <= (state_d == HALT);
        end
    end

    assign PC          = pc_q;
    assign Ack         = ack_q;
    assign Overrun     = overrun_q;
    assign Instr_Valid = (state_q == RUN);

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else if (start_accept) begin
            count_q <= '0;
        end else if ((state_q == RUN) && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign Cycle_Count = count_q;
`else
    assign Cycle_Count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed table-driven bench for fetch_sequencer (PC_W 10 and 9 instances)
module tb_fetch_sequencer;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instance A: default width
    logic        a_rst, a_start, a_halt, a_jmp, a_beq, a_we, a_hi;
    logic [8:0]  a_instr;
    logic [7:0]  a_acc;
    logic [9:0]  a_pc;
    logic        a_valid, a_ack, a_ovr;
    logic [15:0] a_cc;

    // Instance B: PC_W = 9 for the overrun case
    logic        b_rst, b_start, b_halt, b_jmp, b_beq, b_we, b_hi;
    logic [8:0]  b_instr;
    logic [7:0]  b_acc;
    logic [8:0]  b_pc;
    logic        b_valid, b_ack, b_ovr;
    logic [15:0] b_cc;

    fetch_sequencer #(.PC_W(10), .LUT_DEPTH(16)) dut_a (
        .Clk(Clk), .Reset(a_rst), .Start(a_start), .Instruction(a_instr),
        .Acc_Data(a_acc), .Halt_Req(a_halt), .PC_Jmp_Flag(a_jmp),
        .PC_Beq_Flag(a_beq), .LUT_Write_En(a_we), .LUT_Load_Hi(a_hi),
        .PC(a_pc), .Instr_Valid(a_valid), .Ack(a_ack), .Overrun(a_ovr),
        .Cycle_Count(a_cc)
    );

    fetch_sequencer #(.PC_W(9), .LUT_DEPTH(16)) dut_b (
        .Clk(Clk), .Reset(b_rst), .Start(b_start), .Instruction(b_instr),
        .Acc_Data(b_acc), .Halt_Req(b_halt), .PC_Jmp_Flag(b_jmp),
        .PC_Beq_Flag(b_beq), .LUT_Write_En(b_we), .LUT_Load_Hi(b_hi),
        .PC(b_pc), .Instr_Valid(b_valid), .Ack(b_ack), .Overrun(b_ovr),
        .Cycle_Count(b_cc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cc_exp(input int n);
`ifdef FETCH_CYCLE_COUNT_EN
        return 16'(n);
`else
        return 16'd0 + 16'(n & 0);
`endif
    endfunction

    typedef struct {
        logic       start;
        logic [3:0] idx;
        logic [7:0] acc;
        logic       halt, jmp, beq, we, hi;
        logic [9:0] pc;
        logic       valid, ack;
        int         cc;
    } vec_t;

    vec_t vecs [20];

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic a_idle;
        a_start = 0; a_instr = '0; a_acc = '0; a_halt = 0;
        a_jmp = 0; a_beq = 0; a_we = 0; a_hi = 0;
    endtask

    task automatic b_drive(input logic s, input logic [3:0] idx, input logic [7:0] acc,
                           input logic jmp, input logic we, input logic hi);
        b_start = s; b_instr = {5'd0, idx}; b_acc = acc; b_halt = 0;
        b_jmp = jmp; b_beq = 0; b_we = we; b_hi = hi;
    endtask

    initial begin
        //          st idx acc    hlt jmp beq we hi  pc       vld ack cc
        vecs[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 10'h000, 1, 0, 0};
        vecs[1]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 10'h001, 1, 0, 1};
        vecs[2]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 10'h002, 1, 0, 2};
        vecs[3]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 10'h003, 1, 0, 3};
        vecs[4]  = '{0, 0, 8'h00, 1, 0, 0, 0, 0, 10'h003, 0, 1, 4};
        vecs[5]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 10'h000, 1, 0, 0};
        vecs[6]  = '{0, 5, 8'h2C, 0, 0, 0, 1, 0, 10'h001, 1, 0, 1};
        vecs[7]  = '{0, 5, 8'h01, 0, 0, 0, 1, 1, 10'h002, 1, 0, 2};
        vecs[8]  = '{0, 5, 8'h00, 0, 1, 0, 0, 0, 10'h12C, 1, 0, 3};
        vecs[9]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 10'h12D, 1, 0, 4};
        vecs[10] = '{0, 2, 8'h28, 0, 0, 0, 1, 0, 10'h12E, 1, 0, 5};
        vecs[11] = '{0, 2, 8'h50, 0, 0, 1, 1, 0, 10'h028, 1, 0, 6};
        vecs[12] = '{0, 2, 8'h00, 0, 0, 1, 0, 0, 10'h050, 1, 0, 7};
        vecs[13] = '{0, 5, 8'h00, 0, 1, 1, 0, 0, 10'h12C, 1, 0, 8};
        vecs[14] = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 10'h12D, 1, 0, 9};
        vecs[15] = '{0, 0, 8'h00, 1, 0, 0, 0, 0, 10'h12D, 0, 1, 10};
        vecs[16] = '{0, 5, 8'h77, 0, 1, 0, 1, 0, 10'h12D, 0, 1, 10};
        vecs[17] = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 10'h000, 1, 0, 0};
        vecs[18] = '{0, 5, 8'h00, 0, 1, 0, 0, 0, 10'h12C, 1, 0, 1};
        vecs[19] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 10'h12D, 1, 0, 2};

        a_idle();
        b_drive(0, 0, 8'h00, 0, 0, 0);
        a_rst = 1; b_rst = 1;
        tick(); tick();
        chk("rst_pc", 32'(a_pc), 32'h0);
        chk("rst_valid", 32'(a_valid), 32'h0);
        chk("rst_ack", 32'(a_ack), 32'h0);
        chk("rst_ovr", 32'(a_ovr), 32'h0);
        chk("rst_cc", 32'(a_cc), 32'h0);
        a_rst = 0; b_rst = 0;
        tick();
        chk("idle_pc", 32'(a_pc), 32'h0);
        chk("idle_valid", 32'(a_valid), 32'h0);

        for (int i = 0; i < 20; i++) begin
            a_start = vecs[i].start; a_instr = {5'd0, vecs[i].idx}; a_acc = vecs[i].acc;
            a_halt = vecs[i].halt; a_jmp = vecs[i].jmp; a_beq = vecs[i].beq;
            a_we = vecs[i].we; a_hi = vecs[i].hi;
            tick();
            chk($sformatf("v%0d_pc", i), 32'(a_pc), 32'(vecs[i].pc));
            chk($sformatf("v%0d_valid", i), 32'(a_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d_ack", i), 32'(a_ack), 32'(vecs[i].ack));
            chk($sformatf("v%0d_cc", i), 32'(a_cc), 32'(cc_exp(vecs[i].cc)));
        end

        // Run from 0 up to PC 7, then reset asynchronously mid-cycle.
        a_idle();
        a_halt = 1; tick(); a_halt = 0;
        a_start = 1; tick(); a_start = 0;
        for (int i = 0; i < 7; i++) tick();
        chk("pre_rst_pc", 32'(a_pc), 32'h7);
        #2 a_rst = 1;
        #1;
        chk("async_rst_pc", 32'(a_pc), 32'h0);
        chk("async_rst_valid", 32'(a_valid), 32'h0);
        chk("async_rst_ack", 32'(a_ack), 32'h0);
        tick();
        a_rst = 0;
        a_instr = 9'd5; a_beq = 1; tick();
        chk("idle_beq_pc", 32'(a_pc), 32'h0);
        a_beq = 0; tick();
        a_beq = 1; tick(); a_beq = 0;
        chk("idle_beq2_pc", 32'(a_pc), 32'h0);
        chk("idle_beq_valid", 32'(a_valid), 32'h0);
        a_start = 1; tick(); a_start = 0;
        a_jmp = 1; a_instr = 9'd5; tick(); a_jmp = 0;
        chk("lut_cleared_pc", 32'(a_pc), 32'h0);
        chk("lut_cleared_valid", 32'(a_valid), 32'h1);

        // Overrun on the 9-bit instance.
        b_drive(1, 0, 8'h00, 0, 0, 0); tick();
        chk("b_start_pc", 32'(b_pc), 32'h0);
        b_drive(0, 0, 8'hFE, 0, 1, 0); tick();
        b_drive(0, 0, 8'h01, 0, 1, 1); tick();
        b_drive(0, 0, 8'h00, 1, 0, 0); tick();
        chk("b_jmp_pc", 32'(b_pc), 32'h1FE);
        b_drive(0, 0, 8'h00, 0, 0, 0); tick();
        chk("b_last_pc", 32'(b_pc), 32'h1FF);
        chk("b_last_ovr", 32'(b_ovr), 32'h0);
        tick();
        chk("b_ovr_pc", 32'(b_pc), 32'h1FF);
        chk("b_ovr_flag", 32'(b_ovr), 32'h1);
        chk("b_ovr_ack", 32'(b_ack), 32'h1);
        chk("b_ovr_valid", 32'(b_valid), 32'h0);
        chk("b_ovr_cc", 32'(b_cc), 32'(cc_exp(5)));
        tick();
        chk("b_hold_pc", 32'(b_pc), 32'h1FF);
        b_drive(1, 0, 8'h00, 0, 0, 0); tick();
        chk("b_restart_ovr", 32'(b_ovr), 32'h0);
        chk("b_restart_ack", 32'(b_ack), 32'h0);
        chk("b_restart_pc", 32'(b_pc), 32'h0);
        chk("b_restart_cc", 32'(b_cc), 32'h0);
        b_drive(0, 0, 8'h00, 1, 0, 0); tick();
        chk("b_lut_kept_pc", 32'(b_pc), 32'h1FE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
